dca_matrix_lsu_arbiter: RTL
===========================

# dca_matrix_lsu_arbiter

Shares one matrix-LSU instruction port among three requesters inside the DCA GEMM tile: the lhs-load, rhs-load and store instruction sequencers. Grants are issued round-robin into a registered output slot. A tag FIFO records the grant order so that in-order LSU completions are routed back to the requester that issued each instruction. Outstanding-instruction depth is bounded by a parameter.

## Interface
Parameters:
- BW_INST, `BW_DCA_MATRIX_LSU_INST, width of one LSU instruction
- MAX_OUTSTANDING, 4, maximum granted-but-not-completed instructions (power of two, ≥2)

Ports:
- clk  input  1  clock
- rstnn  input  1  reset, asynchronous, active-low
- clear  input  1  synchronous flush of all state
- enable  input  1  gates new grants
- busy  output  1  output slot valid or any tag outstanding
- req_valid_list  input  3  per-requester instruction valid; index 0 = lhs load, 1 = rhs load, 2 = store
- req_ready_list  output  3  per-requester accept (one-hot or zero)
- req_inst_list  input  3*BW_INST  requester i at bits [i*BW_INST +: BW_INST]
- req_done_list  output  3  one-cycle completion pulse to the owning requester
- lsu_inst_valid  output  1  shared LSU instruction valid
- lsu_inst_ready  input  1  shared LSU accepts
- lsu_inst  output  BW_INST  instruction
- lsu_inst_owner  output  2  requester index of lsu_inst
- lsu_done  input  1  LSU completed its oldest instruction (in-order)
- error_underflow  output  1  sticky: lsu_done received with no outstanding tag

## Operation
- State:
  - rr_ptr (2 b, range 0..2)
  - output slot: valid, inst, owner
  - tag FIFO: MAX_OUTSTANDING × 2 b, with count 0..MAX_OUTSTANDING
  - error_underflow
- Reset and clear values: all zero. Every output is 0 after reset.
- can_grant = enable & (!lsu_inst_valid | lsu_inst_ready) & (count < MAX_OUTSTANDING).
- Winner: the first i with req_valid_list[i], searching rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
- req_ready_list = one-hot(winner) when can_grant and any request is valid; otherwise 0. It is combinational from req_valid_list.
- On grant:
  - The slot loads inst and owner, and valid←1.
  - The winner index is pushed into the tag FIFO.
  - rr_ptr←(winner+1) mod 3.
- No grant and lsu_inst_ready: valid←0.
- No grant, no ready: the slot holds and its contents are stable.
- Completion:
  - req_done_list = lsu_done & (count>0) ? one-hot(FIFO head) : 0. This is combinational.
  - Completion pops the head.
- lsu_done with count==0: no pop, no pulse; error_underflow←1 and it stays set until clear or reset.
- Push and pop in the same cycle leave count unchanged. With count==MAX_OUTSTANDING, a simultaneous pop does not enable a grant that cycle, because can_grant uses the registered count.
- clear has priority over every other update. It empties the slot and the FIFO, resets rr_ptr, and clears error_underflow.
- enable=0 only blocks new grants. The slot still drains on lsu_inst_ready and completions are still processed.
- busy = lsu_inst_valid | (count != 0).

## Timing
- Accept at edge N (req_valid & req_ready) → lsu_inst_valid=1 with that instruction from edge N onward (visible in cycle N+1).
- Throughput is one instruction per cycle while lsu_inst_ready=1 and count<MAX_OUTSTANDING.
- Granting one requester every cycle with all three valid gives the order 0,1,2,0,1,2…
- req_done_list pulses in the same cycle as lsu_done; latency 0.
- An asynchronous rstnn assertion mid-transfer drops lsu_inst_valid immediately. Lost tags are not recovered.

## Test plan
- All three valid continuously, lsu_inst_ready=1, lsu_done one cycle after each issue → lsu_inst_owner sequence 0,1,2,0,1,2; req_done_list 001,010,100 in the same order; error_underflow=0.
- Only requester 2 valid, lsu_done never asserted → exactly 4 grants; req_ready_list then stays 000 and busy=1. One lsu_done → req_done_list=100; the next cycle allows a 5th grant.
- lsu_inst_ready=0 for 5 cycles with the slot full → lsu_inst and lsu_inst_owner stay stable and no new grant occurs. Ready=1 with a pending request → back-to-back handoff with no bubble.
- lsu_done pulse with no outstanding tag → no req_done pulse and error_underflow=1 held. clear → error_underflow=0, busy=0, rr_ptr=0.
- enable=0 while the slot is valid and 2 tags are outstanding → the slot drains and both done pulses route correctly, with no new grant. enable=1 → grants resume.
- clear asserted in the same cycle as a grant and an lsu_done → the next cycle has lsu_inst_valid=0 and count=0; rr_ptr is 0, so requester 0 wins first.

Source files
------------

// File: rtl/dca_matrix_lsu_arbiter.sv
// dca_matrix_lsu_arbiter
// Shares one matrix-LSU instruction port among the three instruction
// sequencers of a DCA GEMM tile (0 = lhs load, 1 = rhs load, 2 = store).
// A round-robin winner is loaded into a registered output slot. A tag FIFO
// records grant order, so in-order LSU completions are routed back to the
// requester that issued each instruction.
//
// Ports
//   clk, rstnn        clock, asynchronous active-low reset
//   clear             synchronous flush of all state (highest priority)
//   enable            gates new grants; draining and completions continue
//   busy              slot valid or any tag outstanding
//   req_valid_list    per-requester instruction valid
//   req_ready_list    per-requester accept (one-hot or zero, combinational)
//   req_inst_list     requester i instruction at [i*BW_INST +: BW_INST]
//   req_done_list     one-cycle completion pulse to the owning requester
//   lsu_inst_valid    shared LSU instruction valid
//   lsu_inst_ready    shared LSU accepts
//   lsu_inst          granted instruction
//   lsu_inst_owner    requester index of lsu_inst
//   lsu_done          LSU completed its oldest instruction
//   error_underflow   sticky: lsu_done seen with no outstanding tag

`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_matrix_lsu_arbiter #(
    parameter int BW_INST         = `BW_DCA_MATRIX_LSU_INST,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rstnn,
    input  logic                 clear,
    input  logic                 enable,
    output logic                 busy,
    input  logic [2:0]           req_valid_list,
    output logic [2:0]           req_ready_list,
    input  logic [3*BW_INST-1:0] req_inst_list,
    output logic [2:0]           req_done_list,
    output logic                 lsu_inst_valid,
    input  logic                 lsu_inst_ready,
    output logic [BW_INST-1:0]   lsu_inst,
    output logic [1:0]           lsu_inst_owner,
    input  logic                 lsu_done,
    output logic                 error_underflow
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Increment modulo 3; the illegal code 3 folds back to 0.
    function automatic logic [1:0] mod3_inc(input logic [1:0] idx);
        logic [1:0] nxt;
        case (idx)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

    // Requester index to one-hot; an illegal index yields no pulse.
    function automatic logic [2:0] to_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    logic [1:0]         rr_ptr_r;
    logic               slot_valid_r;
    logic [BW_INST-1:0] slot_inst_r;
    logic [1:0]         slot_owner_r;
    logic [1:0]         tag_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               underflow_r;

    logic [1:0]         cand1_s;
    logic [1:0]         cand2_s;
    logic [1:0]         winner_s;
    logic               any_valid_s;
    logic               can_grant_s;
    logic               grant_s;
    logic               pop_s;
    logic [1:0]         head_tag_s;
    logic [BW_INST-1:0] sel_inst_s;

    // Round-robin search starting at rr_ptr; the chain order is the priority.
    always_comb begin
        cand1_s     = mod3_inc(rr_ptr_r);
        cand2_s     = mod3_inc(cand1_s);
        any_valid_s = |req_valid_list;
        if (req_valid_list[rr_ptr_r]) begin
            winner_s = rr_ptr_r;
        end else if (req_valid_list[cand1_s]) begin
            winner_s = cand1_s;
        end else begin
            winner_s = cand2_s;
        end
    end

    // Grant and completion qualification; count is the registered value, so a
    // pop on a full FIFO cannot open a grant in the same cycle.
    always_comb begin
        can_grant_s = enable & (~slot_valid_r | lsu_inst_ready) & (count_r < CNT_MAX);
        grant_s     = can_grant_s & any_valid_s;
        pop_s       = lsu_done & (count_r != CNT_ZERO);
        head_tag_s  = tag_mem_r[rd_ptr_r];
    end

    // Select the winning requester's instruction.
    always_comb begin
        case (winner_s)
            2'd0:    sel_inst_s = req_inst_list[0*BW_INST +: BW_INST];
            2'd1:    sel_inst_s = req_inst_list[1*BW_INST +: BW_INST];
            2'd2:    sel_inst_s = req_inst_list[2*BW_INST +: BW_INST];
            default: sel_inst_s = {BW_INST{1'b0}};
        endcase
    end

    // Output slot and round-robin pointer.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            slot_valid_r <= 1'b0;
            slot_inst_r  <= {BW_INST{1'b0}};
            slot_owner_r <= 2'd0;
            rr_ptr_r     <= 2'd0;
        end else if (clear) begin
            slot_valid_r <= 1'b0;
            slot_inst_r  <= {BW_INST{1'b0}};
            slot_owner_r <= 2'd0;
            rr_ptr_r     <= 2'd0;
        end else if (grant_s) begin
            slot_valid_r <= 1'b1;
            slot_inst_r  <= sel_inst_s;
            slot_owner_r <= winner_s;
            rr_ptr_r     <= mod3_inc(winner_s);
        end else if (lsu_inst_ready) begin
            slot_valid_r <= 1'b0;
        end
    end

    // Tag FIFO storage: records the owner of every granted instruction.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_r[i] <= 2'd0;
            end
        end else if (clear) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_mem_r[i] <= 2'd0;
            end
        end else if (grant_s) begin
            tag_mem_r[wr_ptr_r] <= winner_s;
        end
    end

    // Tag FIFO pointers and occupancy; pointers wrap naturally (power of two).
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (grant_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({grant_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky underflow flag: completion reported with nothing outstanding.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            underflow_r <= 1'b0;
        end else if (clear) begin
            underflow_r <= 1'b0;
        end else if (lsu_done && (count_r == CNT_ZERO)) begin
            underflow_r <= 1'b1;
        end
    end

    // Output mapping; ready and done are combinational by design.
    always_comb begin
        req_ready_list  = grant_s ? to_onehot(winner_s) : 3'b000;
        req_done_list   = pop_s ? to_onehot(head_tag_s) : 3'b000;
        lsu_inst_valid  = slot_valid_r;
        lsu_inst        = slot_inst_r;
        lsu_inst_owner  = slot_owner_r;
        error_underflow = underflow_r;
        busy            = slot_valid_r | (count_r != CNT_ZERO);
    end

endmodule
